// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I opcodes, immediate formats and widths
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD, JALR: return IMM_I;
            STORE:              return IMM_S;
            BRANCH:             return IMM_B;
            LUI, AUIPC:         return IMM_U;
            JAL:                return IMM_J;
            default:            return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended RV32I immediate by format
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_operand_stage.sv
// rtl/decode_operand_stage.sv - RV32I decode/operand stage with busy scoreboard and ID/EX register
module decode_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  clearAllN,
    input  logic [31:0]           instrIn,
    input  logic [XLEN-1:0]       pcIn,
    input  logic                  instrValid,
    output logic                  instrReady,
    output logic [REG_ADDR_W-1:0] addressRS1,
    output logic [REG_ADDR_W-1:0] addressRS2,
    output logic                  readEnable,
    input  logic [XLEN-1:0]       readRS1,
    input  logic [XLEN-1:0]       readRS2,
    input  logic                  wbEnable,
    input  logic [REG_ADDR_W-1:0] wbAddress,
    input  logic                  flush,
    output logic                  exValid,
    input  logic                  exReady,
    output logic [XLEN-1:0]       exPc,
    output logic [XLEN-1:0]       exRS1Data,
    output logic [XLEN-1:0]       exRS2Data,
    output logic [XLEN-1:0]       exImm,
    output logic [REG_ADDR_W-1:0] exRd,
    output logic [6:0]            exOpcode,
    output logic [2:0]            exFunct3,
    output logic                  exFunct7b5,
    output logic                  exRegWrite
);
    import rv32_pkg::*;

    localparam int NREG = 1 << REG_ADDR_W;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  uses_rs1, uses_rs2, writes_rd, reg_write;
    logic [XLEN-1:0]       imm;
    logic [NREG-1:1]       busy_r;
    logic [NREG-1:0]       busy;
    logic                  hz_rs1, hz_rs2, hz_rd, hazard;
    logic                  capture, handoff, wb_clear;

    assign opcode     = instrIn[6:0];
    assign rs1        = instrIn[19:15];
    assign rs2        = instrIn[24:20];
    assign rd         = instrIn[11:7];
    assign addressRS1 = rs1;
    assign addressRS2 = rs2;
    assign readEnable = instrValid;

    always_comb begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            LUI, AUIPC, JAL: begin
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            OP: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            STORE, BRANCH:      uses_rs2  = 1'b1;
            OP_IMM, LOAD, JALR: writes_rd = 1'b1;
            default: ;
        endcase
    end

    assign reg_write = writes_rd && (rd != '0);

    imm_gen u_imm_gen (
        .instr    (instrIn[31:7]),
        .imm_type (imm_type_of(opcode)),
        .imm      (imm)
    );

    // x0 never goes busy; the held ID/EX entry counts as in flight until handed off
    assign busy   = {busy_r, 1'b0};
    assign hz_rs1 = uses_rs1 && (rs1 != '0) && (busy[rs1] || (exValid && exRegWrite && exRd == rs1));
    assign hz_rs2 = uses_rs2 && (rs2 != '0) && (busy[rs2] || (exValid && exRegWrite && exRd == rs2));
    assign hz_rd  = reg_write && (busy[rd] || (exValid && exRegWrite && exRd == rd));
    assign hazard = hz_rs1 || hz_rs2 || hz_rd;

    assign instrReady = clearAllN && (!exValid || exReady) && !hazard && !flush;
    assign capture    = instrValid && instrReady;
    assign handoff    = exValid && exReady && exRegWrite && !flush;
    assign wb_clear   = wbEnable && (wbAddress != '0);

    // A set from handoff overrides a writeback clear of the same register
    always_ff @(posedge clk or negedge clearAllN) begin
        if (!clearAllN) begin
            busy_r <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (handoff && exRd == REG_ADDR_W'(i))
                    busy_r[i] <= 1'b1;
                else if (wb_clear && wbAddress == REG_ADDR_W'(i))
                    busy_r[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clearAllN) begin
        if (!clearAllN) begin
            exValid    <= 1'b0;
            exPc       <= '0;
            exRS1Data  <= '0;
            exRS2Data  <= '0;
            exImm      <= '0;
            exRd       <= '0;
            exOpcode   <= '0;
            exFunct3   <= '0;
            exFunct7b5 <= 1'b0;
            exRegWrite <= 1'b0;
        end else if (capture) begin
            exValid    <= 1'b1;
            exPc       <= pcIn;
            exRS1Data  <= readRS1;
            exRS2Data  <= readRS2;
            exImm      <= imm;
            exRd       <= rd;
            exOpcode   <= opcode;
            exFunct3   <= instrIn[14:12];
            exFunct7b5 <= instrIn[30];
            exRegWrite <= reg_write;
        end else if (flush || exReady) begin
            exValid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_operand_stage.sv
// tb/tb_decode_operand_stage.sv - self-checking bench for decode_operand_stage
module tb_decode_operand_stage;

    logic        clk = 1'b0;
    logic        clearAllN = 1'b1;
    logic [31:0] instrIn = '0;
    logic [31:0] pcIn = '0;
    logic        instrValid = 1'b0;
    logic        instrReady;
    logic [4:0]  addressRS1, addressRS2;
    logic        readEnable;
    logic [31:0] readRS1, readRS2;
    logic        wbEnable = 1'b0;
    logic [4:0]  wbAddress = '0;
    logic        flush = 1'b0;
    logic        exValid;
    logic        exReady = 1'b0;
    logic [31:0] exPc, exRS1Data, exRS2Data, exImm;
    logic [4:0]  exRd;
    logic [6:0]  exOpcode;
    logic [2:0]  exFunct3;
    logic        exFunct7b5, exRegWrite;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    decode_operand_stage dut (
        .clk(clk), .clearAllN(clearAllN), .instrIn(instrIn), .pcIn(pcIn),
        .instrValid(instrValid), .instrReady(instrReady),
        .addressRS1(addressRS1), .addressRS2(addressRS2), .readEnable(readEnable),
        .readRS1(readRS1), .readRS2(readRS2),
        .wbEnable(wbEnable), .wbAddress(wbAddress), .flush(flush),
        .exValid(exValid), .exReady(exReady), .exPc(exPc),
        .exRS1Data(exRS1Data), .exRS2Data(exRS2Data), .exImm(exImm),
        .exRd(exRd), .exOpcode(exOpcode), .exFunct3(exFunct3),
        .exFunct7b5(exFunct7b5), .exRegWrite(exRegWrite)
    );

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'hA000_0000 | (32'(a) * 32'h111);
    endfunction

    assign readRS1 = rf_val(addressRS1);
    assign readRS2 = rf_val(addressRS2);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          r1;
        bit          r2;
        bit          rw;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t        d;
        logic [6:0]  op;
        int          v;
        op   = ins[6:0];
        d.r1 = !(op inside {7'h37, 7'h17, 7'h6F});
        d.r2 = op inside {7'h33, 7'h23, 7'h63};
        d.rw = (op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h37, 7'h17}) && (ins[11:7] != 0);
        v = 0;
        case (op)
            7'h13, 7'h03, 7'h67: begin
                v = int'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            7'h23: begin
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            7'h63: begin
                v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
            end
            7'h37, 7'h17: v = int'(ins[31:12]) * 4096;
            7'h6F: begin
                v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                if (ins[31]) v -= (1 << 20);
            end
            default: v = 0;
        endcase
        d.imm = 32'(v);
        return d;
    endfunction

    bit          m_valid = 0;
    logic [31:0] m_pc = '0, m_r1 = '0, m_r2 = '0, m_imm = '0, m_ins = '0;
    logic [4:0]  m_rd = '0;
    bit          m_rw = 0;
    bit          m_busy [32];

    function automatic bit blocked(input logic [4:0] r);
        return (r != 0) && (m_busy[r] || (m_valid && m_rw && m_rd == r));
    endfunction

    function automatic bit model_ready();
        dec_t d;
        d = decode(instrIn);
        if (!clearAllN || flush) return 0;
        if (m_valid && !exReady) return 0;
        if (d.r1 && blocked(instrIn[19:15])) return 0;
        if (d.r2 && blocked(instrIn[24:20])) return 0;
        if (d.rw && blocked(instrIn[11:7])) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = m_busy[i];
        return b;
    endfunction

    always @(posedge clk or negedge clearAllN) begin : model
        bit   rdy, ho;
        dec_t d;
        if (!clearAllN) begin
            m_valid = 0; m_pc = '0; m_r1 = '0; m_r2 = '0; m_imm = '0;
            m_ins = '0; m_rd = '0; m_rw = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            rdy = model_ready();
            d   = decode(instrIn);
            ho  = m_valid && exReady && m_rw && !flush;
            if (wbEnable && wbAddress != 0) m_busy[wbAddress] = 0;
            if (ho) m_busy[m_rd] = 1;
            if (instrValid && rdy) begin
                m_valid = 1;
                m_pc    = pcIn;
                m_r1    = rf_val(instrIn[19:15]);
                m_r2    = rf_val(instrIn[24:20]);
                m_imm   = d.imm;
                m_ins   = instrIn;
                m_rd    = instrIn[11:7];
                m_rw    = d.rw;
            end else if (flush) begin
                m_valid = 0;
            end else if (m_valid && exReady) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("exValid",    32'(exValid),    32'(m_valid));
            chk("exPc",       exPc,            m_pc);
            chk("exRS1Data",  exRS1Data,       m_r1);
            chk("exRS2Data",  exRS2Data,       m_r2);
            chk("exImm",      exImm,           m_imm);
            chk("exRd",       32'(exRd),       32'(m_rd));
            chk("exOpcode",   32'(exOpcode),   32'(m_ins[6:0]));
            chk("exFunct3",   32'(exFunct3),   32'(m_ins[14:12]));
            chk("exFunct7b5", 32'(exFunct7b5), 32'(m_ins[30]));
            chk("exRegWrite", 32'(exRegWrite), 32'(m_rw));
            chk("instrReady", 32'(instrReady), 32'(model_ready()));
            chk("readEnable", 32'(readEnable), 32'(instrValid));
            chk("addressRS1", 32'(addressRS1), 32'(instrIn[19:15]));
            chk("addressRS2", 32'(addressRS2), 32'(instrIn[24:20]));
            chk("busy",       dut.busy,        busy_vec());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output int waits);
        instrIn    = ins;
        pcIn       = pc;
        instrValid = 1'b1;
        waits      = 0;
        forever begin
            @(negedge clk);
            if (instrReady) break;
            waits++;
            if (waits > 40) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: instr %h not accepted within 40 cycles", ins);
                break;
            end
        end
        @(posedge clk);
        #1;
        instrValid = 1'b0;
    endtask

    task automatic wb_clear(input logic [4:0] r);
        wbEnable  = 1'b1;
        wbAddress = r;
        cyc();
        wbEnable  = 1'b0;
    endtask

    initial begin
        int w1, w2, w;
        #1;
        clearAllN  = 1'b0;
        chk_en     = 1'b1;
        instrIn    = 32'h0050_0093;
        instrValid = 1'b1;
        #2;
        chk("rst_exValid",    32'(exValid),    32'h0);
        chk("rst_exPc",       exPc,            32'h0);
        chk("rst_instrReady", 32'(instrReady), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        clearAllN  = 1'b1;
        instrValid = 1'b0;
        cyc();

        // back-to-back independent ops
        exReady = 1'b1;
        issue(32'h0050_0093, 32'h100, w1);
        chk("t1_imm5", exImm, 32'd5);
        issue(32'h0070_0113, 32'h104, w2);
        chk("t1_imm7", exImm, 32'd7);
        chk("t1_no_stall", 32'(w1 + w2), 32'd0);
        cyc();
        chk("t1_busy_x1_x2", dut.busy, 32'h0000_0006);

        // RAW stall released by writeback of x1
        instrIn    = 32'h0010_81B3;
        pcIn       = 32'h108;
        instrValid = 1'b1;
        cyc();
        @(negedge clk);
        chk("t2_stall", 32'(instrReady), 32'h0);
        @(posedge clk); #1;
        wbEnable  = 1'b1;
        wbAddress = 5'd1;
        @(negedge clk);
        chk("t2_stall_wb_cycle", 32'(instrReady), 32'h0);
        @(posedge clk); #1;
        wbEnable = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_wb", 32'(instrReady), 32'h1);
        @(posedge clk); #1;
        instrValid = 1'b0;
        chk("t2_rs1data", exRS1Data, 32'hA000_0111);
        chk("t2_rd", 32'(exRd), 32'd3);
        cyc();
        wb_clear(5'd2);
        wb_clear(5'd3);

        // backpressure hold
        exReady = 1'b0;
        issue(32'h0090_0213, 32'h200, w);
        instrIn    = 32'h0010_0313;
        pcIn       = 32'h204;
        instrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_ready", 32'(instrReady), 32'h0);
            chk("t3_hold_pc",    exPc,            32'h200);
            chk("t3_hold_imm",   exImm,           32'd9);
            chk("t3_hold_rd",    32'(exRd),       32'd4);
            @(posedge clk); #1;
        end

        // handoff of x4 colliding with writeback of x4
        exReady   = 1'b1;
        wbEnable  = 1'b1;
        wbAddress = 5'd4;
        @(negedge clk);
        chk("t4_ready", 32'(instrReady), 32'h1);
        @(posedge clk); #1;
        wbEnable   = 1'b0;
        instrValid = 1'b0;
        chk("t4_set_wins", 32'(dut.busy[4]), 32'h1);
        chk("t4_next_pc", exPc, 32'h204);
        cyc();
        wb_clear(5'd4);
        wb_clear(5'd6);

        // flush with exReady in the same cycle
        exReady = 1'b0;
        issue(32'h0030_0293, 32'h300, w);
        flush      = 1'b1;
        exReady    = 1'b1;
        instrIn    = 32'h0012_8413;
        pcIn       = 32'h304;
        instrValid = 1'b1;
        @(negedge clk);
        chk("t5_flush_blocks", 32'(instrReady), 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t5_exValid", 32'(exValid), 32'h0);
        chk("t5_busy5", 32'(dut.busy[5]), 32'h0);
        issue(32'h0012_8413, 32'h304, w);
        chk("t5_no_stall", 32'(w), 32'd0);
        chk("t5_rs1data", exRS1Data, 32'hA000_0555);
        cyc();
        wb_clear(5'd8);

        // immediates and x0
        issue(32'hFE20_AE23, 32'h400, w);
        chk("t6_s_imm", exImm, 32'hFFFF_FFFC);
        issue(32'hFE00_0CE3, 32'h404, w);
        chk("t6_b_imm", exImm, 32'hFFFF_FFF8);
        issue(32'h0010_006F, 32'h408, w);
        chk("t6_j_imm", exImm, 32'h0000_0800);
        issue(32'h1234_53B7, 32'h40C, w);
        chk("t6_u_imm", exImm, 32'h1234_5000);
        chk("t6_u_rw", 32'(exRegWrite), 32'h1);
        issue(32'h0010_0013, 32'h410, w);
        chk("t6_x0_rw", 32'(exRegWrite), 32'h0);
        cyc();
        cyc();
        chk("t6_busy_x7_only", dut.busy, 32'h0000_0080);

        // asynchronous reset during a stall
        exReady = 1'b0;
        issue(32'h0010_0513, 32'h500, w);
        instrIn    = 32'h0003_8493;
        pcIn       = 32'h504;
        instrValid = 1'b1;
        @(negedge clk);
        chk("t7_stall", 32'(instrReady), 32'h0);
        @(posedge clk);
        #2;
        clearAllN = 1'b0;
        #1;
        chk("t7_exValid", 32'(exValid), 32'h0);
        chk("t7_busy", dut.busy, 32'h0);
        chk("t7_exPc", exPc, 32'h0);
        chk("t7_ready", 32'(instrReady), 32'h0);
        @(posedge clk); #1;
        clearAllN  = 1'b1;
        instrValid = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- ID stage of the pipelined RV32I core, sitting directly upstream of the 32-entry register file.
- Accepts fetched instructions and decodes rs1/rs2/rd/immediate.
- Drives the register file's combinational read ports and captures the operands into the ID/EX pipeline register under a valid/ready handshake.
- Keeps a per-register busy scoreboard, cleared by writeback, and stalls on RAW/WAW hazards.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register address width (32 architectural registers)

Ports:
clk  in  1  rising-edge clock
clearAllN  in  1  reset, asynchronous, active-low
instrIn  in  32  instruction word from fetch
pcIn  in  XLEN  PC of instrIn
instrValid  in  1  fetch presents an instruction
instrReady  out  1  stage accepts instruction this cycle
addressRS1  out  REG_ADDR_W  register file rs1 read address (instrIn[19:15])
addressRS2  out  REG_ADDR_W  register file rs2 read address (instrIn[24:20])
readEnable  out  1  register file read enable (= instrValid)
readRS1  in  XLEN  rs1 data (combinational, same cycle)
readRS2  in  XLEN  rs2 data (combinational, same cycle)
wbEnable  in  1  writeback commits this cycle
wbAddress  in  REG_ADDR_W  writeback destination
flush  in  1  kill held and incoming instruction (branch redirect)
exValid  out  1  ID/EX register holds valid instruction
exReady  in  1  execute consumes this cycle
exPc, exRS1Data, exRS2Data, exImm  out  XLEN  captured operands
exRd  out  REG_ADDR_W  destination
exOpcode  out  7  opcode
exFunct3  out  3  funct3
exFunct7b5  out  1  instr[30]
exRegWrite  out  1  instruction writes rd (rd != 0)

Behaviour:
- Reset (async, clearAllN low): exValid=0, all ex* data outputs=0, scoreboard all clear. instrReady is combinational and is 0 during reset.
- Decode: usesRS1 for all opcodes except LUI, AUIPC, JAL. usesRS2 for R-type, STORE, BRANCH. regWrite for R, I-ALU, LOAD, JALR, JAL, LUI, AUIPC, and only when rd!=0.
- Immediate, sign-extended to XLEN:
  - I: instr[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type: 0
- Hazard, combinational, for each used rs where rs!=0: busy[rs], OR (exValid & exRegWrite & exRd==rs).
- WAW: same test applied to rd when regWrite.
- instrReady = (!exValid | exReady) & !hazard & !flush.
- Capture: on instrValid & instrReady, load the ID/EX register and set exValid=1 next cycle. Latency is 1 cycle, so throughput is 1 instr/cycle absent hazards.
- Hold: exValid & !exReady keeps all ex* outputs stable.
- Drain: exValid & exReady with no capture clears exValid.
- Scoreboard set: on exValid & exReady & exRegWrite, busy[exRd] <= 1 (handoff to execute).
- Scoreboard clear: on wbEnable & wbAddress!=0, busy[wbAddress] <= 0.
- Same-cycle set and clear of the same register: set wins.
- busy[0] is hardwired 0.
- The register file is not write-through. A reader whose source clears this cycle stalls this cycle and issues next cycle; there is no bypass from writeback.
- flush:
  - exValid <= 0 next edge.
  - instrReady = 0, no capture.
  - The scoreboard is untouched; entries already handed off still write back.
- flush & exReady same cycle: flush dominates, and no scoreboard set occurs for the killed entry.
- Unknown opcode: passed through with exRegWrite=0 and imm=0; trapping is decided downstream.

Decomposition:
- Shared package `rv32_pkg`:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - immediate-type encoding (IMM_I/S/B/U/J/NONE)
  - XLEN and REG_ADDR_W
- Sub-module `imm_gen` (purely combinational: instr -> imm by type), reused later by the branch unit.
- Scoreboard and pipeline register stay in the top module.

Test Plan:
- Back-to-back independent ops:
  - Stimulus: addi x1,x0,5 (0x00500093), then addi x2,x0,7, exReady=1, wbEnable=0.
  - Response: exValid asserted one cycle after each accept; exImm=5 then 7; instrReady never drops.
- RAW stall via held entry and scoreboard:
  - Stimulus: addi x1,x0,5, then add x3,x1,x1.
  - Response: add stalls while busy[1]. With wbEnable,wbAddress=1 at cycle N, the add is accepted at N+1 with exRS1Data=readRS1.
- Backpressure:
  - Stimulus: exReady=0 for 3 cycles with exValid=1.
  - Response: exPc/exImm/exRd stable, instrReady=0. exReady=1 -> handoff, busy[exRd] set.
- Set/clear collision:
  - Stimulus: handoff with exRd=4 while wbEnable,wbAddress=4.
  - Response: busy[4]=1 afterwards.
- Flush:
  - Stimulus: flush with exValid=1 holding rd=5.
  - Response: exValid=0 next cycle, busy[5] unchanged (0), the next instruction reading x5 is not stalled.
- Immediates and x0:
  - Stimulus: sw x2,-4(x1), beq offset -8, jal offset 0x800, lui 0x12345, addi x0,x0,1.
  - Response: exImm = 0xFFFFFFFC, 0xFFFFFFF8, 0x00000800, 0x12345000. addi x0 gives exRegWrite=0 and never sets busy.
- Async reset:
  - Stimulus: clearAllN low mid-stall.
  - Response: exValid=0 and scoreboard clear immediately, without a clock edge.
